// File: rtl/global_mem_reader.sv
// Read-side sequencer for the global-memory LSRAM port B (MAC clock domain).
// Issues credit-limited burst reads and streams the words out via valid/ready.
module global_mem_reader #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 18,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              macclk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W-1:0] cmd_len,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic              busy,
    output logic              done
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] { IDLE, ISSUE, DRAIN } state_e;

    generate
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
            $error("RD_LAT must be in 1..4");
        end
        if (FIFO_DEPTH < RD_LAT + 1) begin : g_bad_depth
            $error("FIFO_DEPTH must be >= RD_LAT+1");
        end
    endgenerate

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_ren_q, mem_ren_d;
    logic              ren_last_q, ren_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [RD_LAT-1:0] vld_sr_q, vld_sr_d;
    logic [RD_LAT-1:0] lst_sr_q, lst_sr_d;

    logic [DATA_W-1:0]     fifo_data_q [FIFO_DEPTH];
    logic [DATA_W-1:0]     fifo_data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last_q, fifo_last_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic push, push_last, pop, can_issue;
    int   inflight, credit;

    assign push      = vld_sr_q[RD_LAT-1];
    assign push_last = lst_sr_q[RD_LAT-1];
    assign o_valid   = (cnt_q != '0);
    assign pop       = o_valid && o_ready;
    assign o_data    = fifo_data_q[rd_ptr_q];
    assign o_last    = o_valid && fifo_last_q[rd_ptr_q];
    assign cmd_ready = (state_q == IDLE);
    assign mem_ren   = mem_ren_q;
    assign mem_addr  = mem_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // The read leaving the issue register counts as in flight too; a pop
    // this cycle frees its slot so steady streaming keeps one read per cycle.
    always_comb begin
        inflight = int'(mem_ren_q);
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + int'(vld_sr_q[i]);
        end
        credit    = int'(cnt_q) + inflight - int'(pop);
        can_issue = (state_q == ISSUE) && (credit < FIFO_DEPTH);
    end

    always_ff @(posedge macclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_valid && cmd_len != '0) state_d = ISSUE;
            ISSUE:   if (can_issue && rem_q == ADDR_W'(1)) state_d = DRAIN;
            DRAIN:   if (done_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        rem_d      = rem_q;
        mem_ren_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        ren_last_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len != '0) begin
                        addr_d = cmd_base;
                        rem_d  = cmd_len;
                        busy_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (can_issue) begin
                    mem_ren_d  = 1'b1;
                    mem_addr_d = addr_q;
                    addr_d     = addr_q + ADDR_W'(1);
                    rem_d      = rem_q - ADDR_W'(1);
                    ren_last_d = (rem_q == ADDR_W'(1));
                end
            end
            DRAIN: begin
                if (pop && o_last) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        vld_sr_d    = vld_sr_q;
        lst_sr_d    = lst_sr_q;
        vld_sr_d[0] = mem_ren_q;
        lst_sr_d[0] = ren_last_q;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
            lst_sr_d[i] = lst_sr_q[i-1];
        end
    end

    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = mem_dout;
            fifo_last_d[wr_ptr_q] = push_last;
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge macclk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            rem_q       <= '0;
            mem_ren_q   <= 1'b0;
            mem_addr_q  <= '0;
            ren_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vld_sr_q    <= '0;
            lst_sr_q    <= '0;
            fifo_data_q <= '{default: '0};
            fifo_last_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            mem_ren_q   <= mem_ren_d;
            mem_addr_q  <= mem_addr_d;
            ren_last_q  <= ren_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            vld_sr_q    <= vld_sr_d;
            lst_sr_q    <= lst_sr_d;
            fifo_data_q <= fifo_data_d;
            fifo_last_q <= fifo_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    a_no_overflow: assert property (@(posedge macclk) disable iff (!rst_n)
        !(push && !pop && cnt_q == CNT_W'(FIFO_DEPTH)));

endmodule
